// File: rtl/hc_sr04_emu_if.sv
// hc_sr04_emu_if -- trig/echo link between an HC-SR04 trig driver (master)
// and the sensor emulator (slave).
//   trig       master -> slave  trigger pulse, asynchronous to the slave clock
//   dist_cm    master -> slave  emulated target distance in cm
//   echo       slave -> master  echo pulse, width encodes distance
//   busy       slave -> master  measurement in progress (trig ignored)
//   meas_done  slave -> master  one-cycle end-of-measurement strobe
interface hc_sr04_emu_if;
    logic       trig;
    logic [8:0] dist_cm;
    logic       echo;
    logic       busy;
    logic       meas_done;

    modport master (output trig, output dist_cm, input echo, input busy, input meas_done);
    modport slave  (input trig, input dist_cm, output echo, output busy, output meas_done);
endinterface

// File: rtl/hc_sr04_emu.sv
// hc_sr04_emu -- synthesizable behavioural model of the HC-SR04 ultrasonic
// sensor (responder end of trig/echo). A trig pulse of at least TRIG_MIN_US
// starts a measurement: after BURST_DELAY_US the echo pin goes high for
// dist_cm*US_PER_CM us, then the block holds off until CYCLE_US has elapsed
// since the trig was accepted.
//
// Ports:
//   sys_clk   system clock (CLK_FREQ_MHZ cycles per us)
//   sys_rst   synchronous reset, active-high
//   sensor    hc_sr04_emu_if.slave: trig, dist_cm in; echo, busy, meas_done out
//
// Build option HCSR04_EMU_TIMEOUT_EN: when defined, an out-of-range distance
// (0 or > MAX_CM) returns a fixed 38000 us echo (the real sensor's no-object
// timeout); when undefined it returns no echo and meas_done pulses at the
// moment the echo would have risen.
module hc_sr04_emu #(
    parameter int CLK_FREQ_MHZ   = 50,
    parameter int TRIG_MIN_US    = 10,
    parameter int BURST_DELAY_US = 200,
    parameter int US_PER_CM      = 58,
    parameter int MAX_CM         = 400,
    parameter int CYCLE_US       = 60000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    hc_sr04_emu_if.slave  sensor
);

    localparam int            PW         = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PW-1:0] PRESC_TC   = PW'(CLK_FREQ_MHZ - 1);
    localparam int            TIMEOUT_US = 38000;

    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

    state_t        state, state_n;
    logic          trig_s1, trig_s2, trig_d;
    logic          rise, fall;
    logic [PW-1:0] presc;
    logic          tick;
    logic [16:0]   us_cnt;     // us spent in the current state
    logic [17:0]   us_nxt;     // us_cnt including this cycle's tick
    logic [17:0]   cyc_us;     // us since BURST entry, runs through HOLDOFF
    logic [18:0]   cyc_nxt;
    logic [16:0]   width_us;
    logic [16:0]   prod;
    logic          oor;
    logic          latch, done_n;
    logic          echo_q, busy_q, done_q;
`ifndef HCSR04_EMU_TIMEOUT_EN
    logic          oor_lat;
`endif

    // trig: 2-FF synchronizer plus one edge-detect stage
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= sensor.trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign rise    = trig_s2 & ~trig_d;
    assign fall    = ~trig_s2 & trig_d;
    assign tick    = (presc == PRESC_TC);
    assign us_nxt  = {1'b0, us_cnt} + {17'd0, tick};
    assign cyc_nxt = {1'b0, cyc_us} + {18'd0, tick};
    assign oor     = (sensor.dist_cm == 9'd0) || (int'(sensor.dist_cm) > MAX_CM);
    assign prod    = 17'(sensor.dist_cm) * 17'(US_PER_CM);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE:    if (rise) state_n = TRIG_HI;
            TRIG_HI: if (fall) begin
                // the tick landing on the fall cycle still counts toward the pulse
                if (us_nxt >= 18'(TRIG_MIN_US)) begin
                    state_n = BURST;
                    latch   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            BURST: if (tick && us_cnt == 17'(BURST_DELAY_US - 1)) begin
`ifdef HCSR04_EMU_TIMEOUT_EN
                state_n = ECHO;
`else
                if (oor_lat) begin
                    state_n = HOLDOFF;
                    done_n  = 1'b1;
                end else begin
                    state_n = ECHO;
                end
`endif
            end
            ECHO: if (tick && us_cnt == width_us - 17'd1) begin
                state_n = HOLDOFF;
                done_n  = 1'b1;
            end
            // an already-expired cycle (echo ran past CYCLE_US) leaves at once
            HOLDOFF: if (cyc_nxt >= 19'(CYCLE_US)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Prescaler and us counters restart on every state entry; transitions
    // after BURST fall on tick boundaries so cyc_us stays exact across them.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc    <= '0;
            us_cnt   <= '0;
            cyc_us   <= '0;
            width_us <= '0;
`ifndef HCSR04_EMU_TIMEOUT_EN
            oor_lat  <= 1'b0;
`endif
        end else begin
            if (state_n != state || tick) presc <= '0;
            else                          presc <= presc + 1'b1;

            if (state_n != state)             us_cnt <= '0;
            else if (tick && us_cnt != '1)    us_cnt <= us_cnt + 1'b1;

            if (state == IDLE || state == TRIG_HI) cyc_us <= '0;
            else if (tick && cyc_us != '1)         cyc_us <= cyc_us + 1'b1;

            if (latch) begin
`ifdef HCSR04_EMU_TIMEOUT_EN
                width_us <= oor ? 17'(TIMEOUT_US) : prod;
`else
                width_us <= prod;
                oor_lat  <= oor;
`endif
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            echo_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            echo_q <= (state_n == ECHO);
            busy_q <= (state_n == BURST) || (state_n == ECHO) || (state_n == HOLDOFF);
            done_q <= done_n;
        end
    end

    assign sensor.echo      = echo_q;
    assign sensor.busy      = busy_q;
    assign sensor.meas_done = done_q;

endmodule

// File: tb/tb_hc_sr04_emu.sv
// tb_hc_sr04_emu -- self-checking bench for hc_sr04_emu, run with scaled-down
// timing parameters. Echo pulses are checked by a monitor against a queue of
// expected (latency, width) pairs pushed by the scenario tasks.
module tb_hc_sr04_emu;
`ifdef HCSR04_EMU_TIMEOUT_EN
    localparam int CLK = 1;
`else
    localparam int CLK = 2;
`endif
    localparam int TRIG_MIN = 10;
    localparam int BURST    = 20;
    localparam int UPC      = 3;
    localparam int MAXCM    = 400;
    localparam int CYC      = 1000;
    localparam int TMO      = 38000;
    // pin fall -> echo rise: 2 sync stages + edge detect, then the burst delay
    localparam int LAT      = BURST * CLK + 3;

    typedef struct {
        int lat;
        int width;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hc_sr04_emu_if sensor();

    hc_sr04_emu #(
        .CLK_FREQ_MHZ(CLK), .TRIG_MIN_US(TRIG_MIN), .BURST_DELAY_US(BURST),
        .US_PER_CM(UPC), .MAX_CM(MAXCM), .CYCLE_US(CYC)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .sensor (sensor)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   done_cnt = 0;
    bit   abort_echo = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // echo/meas_done monitor
    initial begin
        bit   in_echo;
        int   rise_cyc;
        exp_t e;
        in_echo  = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst || abort_echo) begin
                in_echo = 1'b0;
            end else begin
                if (sensor.meas_done) done_cnt++;
                if (sensor.echo && !in_echo) begin
                    in_echo  = 1'b1;
                    rise_cyc = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL echo_unexpected: echo rose at cycle %0d, required no echo", cyc);
                    end else if (cyc - fall_cyc != exp_q[0].lat) begin
                        errors++;
                        $display("FAIL echo_latency: got %0d cycles, required %0d", cyc - fall_cyc, exp_q[0].lat);
                    end
                end else if (!sensor.echo && in_echo) begin
                    in_echo = 1'b0;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (cyc - rise_cyc != e.width) begin
                            errors++;
                            $display("FAIL echo_width: got %0d cycles, required %0d", cyc - rise_cyc, e.width);
                        end
                        checks++;
                        if (sensor.meas_done !== 1'b1) begin
                            errors++;
                            $display("FAIL done_at_echo_fall: got %b, required 1", sensor.meas_done);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic drive_trig(input int us);
        @(negedge clk);
        sensor.trig = 1'b1;
        repeat (us * CLK) @(negedge clk);
        sensor.trig = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_busy_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!sensor.busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sensor.trig = 1'b0;
        sensor.dist_cm = 9'd100;
        repeat (3) @(negedge clk);
        checks++; if (sensor.echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b, required 0", sensor.echo); end
        checks++; if (sensor.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", sensor.busy); end
        checks++; if (sensor.meas_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", sensor.meas_done); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (sensor.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", sensor.busy); end
    endtask

    task automatic test_normal();
        int d0;
        bit ok;
        sensor.dist_cm = 9'd100;
        d0 = done_cnt;
        exp_q.push_back('{lat: LAT, width: 100 * UPC * CLK});
        drive_trig(12);
        repeat (3) @(negedge clk);
        checks++; if (sensor.busy !== 1'b1) begin errors++; $display("FAIL normal_busy_set: got %b, required 1", sensor.busy); end
        wait_busy_low(CYC * CLK + 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL normal_busy_timeout: busy still high, required low"); end
        else if (cyc - fall_cyc != 3 + CYC * CLK) begin
            errors++; $display("FAIL normal_busy_len: got %0d cycles, required %0d", cyc - fall_cyc, 3 + CYC * CLK);
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL normal_done_count: got %0d, required 1", done_cnt - d0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL normal_echo_missing: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_short_trig();
        int  lens[2] = '{8, 9};
        int  d0;
        bit  seen, ok;
        sensor.dist_cm = 9'd100;
        d0 = done_cnt;
        foreach (lens[k]) begin
            drive_trig(lens[k]);
            seen = 1'b0;
            for (int i = 0; i < LAT + 20; i++) begin
                @(negedge clk);
                if (sensor.busy || sensor.echo) seen = 1'b1;
            end
            checks++;
            if (seen) begin errors++; $display("FAIL short_trig_%0d: got response, required none", lens[k]); end
        end
        exp_q.push_back('{lat: LAT, width: 100 * UPC * CLK});
        drive_trig(10);
        repeat (3) @(negedge clk);
        checks++; if (sensor.busy !== 1'b1) begin errors++; $display("FAIL min_trig_busy: got %b, required 1", sensor.busy); end
        wait_busy_low(CYC * CLK + 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL min_trig_timeout: busy still high, required low"); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL min_trig_done: got %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_busy_ignore();
        int d0, f0;
        bit ok;
        sensor.dist_cm = 9'd50;
        d0 = done_cnt;
        exp_q.push_back('{lat: LAT, width: 50 * UPC * CLK});
        drive_trig(12);
        f0 = fall_cyc;
        ok = 1'b0;
        for (int i = 0; i < LAT + 50 * UPC * CLK + 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL ignore_first_echo: no echo, required one"); end
        repeat (500 * CLK) @(negedge clk);
        checks++; if (sensor.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b, required 1", sensor.busy); end
        drive_trig(12);
        wait_busy_low(CYC * CLK, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ignore_busy_timeout: busy still high, required low"); end
        else if (cyc - f0 != 3 + CYC * CLK) begin
            errors++; $display("FAIL ignore_busy_len: got %0d cycles, required %0d", cyc - f0, 3 + CYC * CLK);
        end
        repeat (LAT + 40) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d, required 1", done_cnt - d0); end
        checks++; if (sensor.busy !== 1'b0) begin errors++; $display("FAIL ignore_rearm: busy %b, required 0", sensor.busy); end
    endtask

    task automatic test_out_of_range(input logic [8:0] d);
        int d0;
        bit ok;
        sensor.dist_cm = d;
        d0 = done_cnt;
`ifdef HCSR04_EMU_TIMEOUT_EN
        exp_q.push_back('{lat: LAT, width: TMO * CLK});
        drive_trig(12);
        repeat (3) @(negedge clk);
        wait_busy_low(LAT + TMO * CLK + 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL oor_%0d_busy_timeout: busy still high, required low", d); end
        else if (cyc - fall_cyc != LAT + TMO * CLK + 1) begin
            errors++; $display("FAIL oor_%0d_busy_len: got %0d, required %0d", d, cyc - fall_cyc, LAT + TMO * CLK + 1);
        end
`else
        drive_trig(12);
        ok = 1'b0;
        for (int i = 0; i < LAT + 50; i++) begin
            @(negedge clk);
            if (sensor.meas_done) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL oor_%0d_done_timeout: no meas_done, required one", d); end
        else if (cyc - fall_cyc != LAT) begin
            errors++; $display("FAIL oor_%0d_done_time: got %0d, required %0d", d, cyc - fall_cyc, LAT);
        end
        wait_busy_low(CYC * CLK + 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL oor_%0d_busy_timeout: busy still high, required low", d); end
        else if (cyc - fall_cyc != 3 + CYC * CLK) begin
            errors++; $display("FAIL oor_%0d_busy_len: got %0d, required %0d", d, cyc - fall_cyc, 3 + CYC * CLK);
        end
`endif
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL oor_%0d_done_count: got %0d, required 1", d, done_cnt - d0); end
    endtask

    task automatic test_reset_mid_echo();
        bit ok;
        sensor.dist_cm = 9'd100;
        exp_q.push_back('{lat: LAT, width: 100 * UPC * CLK});
        drive_trig(12);
        ok = 1'b0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (sensor.echo) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_no_echo: echo low, required high"); end
        repeat (50) @(negedge clk);
        abort_echo = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (sensor.echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo: got %b, required 0", sensor.echo); end
        checks++; if (sensor.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", sensor.busy); end
        checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL rst_mid_queue: got %0d pending, required 1", exp_q.size()); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (5) @(negedge clk);
        abort_echo = 1'b0;
        test_normal();
    endtask

    task automatic test_latch();
        int d0;
        bit ok;
        sensor.dist_cm = 9'd400;
        d0 = done_cnt;
        exp_q.push_back('{lat: LAT, width: 400 * UPC * CLK});
        drive_trig(12);
        repeat (5 * CLK) @(negedge clk);
        sensor.dist_cm = 9'd5;
        wait_busy_low(LAT + 400 * UPC * CLK + 50, ok);
        // echo outlasts CYCLE_US here, so busy drops right after meas_done
        checks++;
        if (!ok) begin errors++; $display("FAIL latch_busy_timeout: busy still high, required low"); end
        else if (cyc - fall_cyc != LAT + 400 * UPC * CLK + 1) begin
            errors++; $display("FAIL latch_busy_len: got %0d, required %0d", cyc - fall_cyc, LAT + 400 * UPC * CLK + 1);
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL latch_done_count: got %0d, required 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short_trig();
        test_busy_ignore();
        test_out_of_range(9'd0);
        test_out_of_range(9'd450);
        test_reset_mid_echo();
        test_latch();
        repeat (20) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
